// File: rtl/mips_pkg.sv
// Shared fetch-stage types: NOP encoding, reset PC default, fetch FSM states, IF/ID record.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    function automatic ifid_t make_bubble(input logic [31:0] nop);
        ifid_t b;
        b.instr    = nop;
        b.pc_plus4 = 32'h0;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; one-cycle latency, flush beats hold, hold keeps contents.
module ifid_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  hold,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            q <= make_bubble(NOP_WORD);
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, BOOT/RUN/HALT control and IF/ID capture; imem_addr is combinational from pc.
// Stall holds PC and IF/ID; a redirect overrides stall and costs one bubble.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_BYTES = 65536,
    parameter logic [31:0] NOP_WORD   = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  count;
    logic         fault;
    logic         out_of_range;
    logic         flush;
    logic         hold;
    ifid_t        ifid_d;
    ifid_t        ifid_q;

    assign pc_plus4     = pc + 32'd4;
    assign out_of_range = (pc > PC_MAX);

    // Outside RUN the register only ever takes bubbles.
    always_comb begin
        flush = 1'b1;
        hold  = 1'b0;
        if (state == RUN) begin
            if (redirect_valid) begin
                flush = 1'b1;
            end else if (stall) begin
                flush = 1'b0;
                hold  = 1'b1;
            end else begin
                flush = out_of_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
            fault <= 1'b0;
            count <= 32'h0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (redirect_valid) begin
                        pc <= {redirect_target[31:2], 2'b00};
                        if (redirect_target[1:0] != 2'b00) fault <= 1'b1;
                    end else if (!stall) begin
                        if (out_of_range) begin
                            fault <= 1'b1;
                            state <= HALT;
                        end else begin
                            pc    <= pc_plus4;
                            count <= count + 32'd1;
                            if (halt_req) state <= HALT;
                        end
                    end
                end
                HALT:    state <= HALT;
                default: state <= BOOT;
            endcase
        end
    end

    assign ifid_d.instr    = imem_data;
    assign ifid_d.pc_plus4 = pc_plus4;
    assign ifid_d.valid    = 1'b1;

    ifid_reg #(.NOP_WORD(NOP_WORD)) u_ifid (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (hold),
        .flush (flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_addr     = pc;
    assign ifid_instr    = ifid_q.instr;
    assign ifid_pc_plus4 = ifid_q.pc_plus4;
    assign ifid_valid    = ifid_q.valid;
    assign fetch_fault   = fault;
    assign fetch_count   = count;

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized checks of if_stage against a rule-level fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [16384];
    assign imem_data = mem[imem_addr[15:2]];

    always #5 clk = ~clk;

    if_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .ifid_instr      (ifid_instr),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .ifid_valid      (ifid_valid),
        .fetch_fault     (fetch_fault),
        .fetch_count     (fetch_count)
    );

    int checks = 0;
    int errors = 0;

    // Model: fetching = false until the boot cycle passes; halted stops everything.
    bit          m_booted;
    bit          m_halted;
    logic [31:0] m_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_fault;
    logic [31:0] e_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic rv,
                              input logic [31:0] t, input logic h);
        if (!r) begin
            m_booted = 0; m_halted = 0; m_pc = 32'h0;
            e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 0; e_fault = 0; e_count = 0;
        end else if (!m_booted) begin
            m_booted = 1;
            e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 0;
        end else if (m_halted) begin
            e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 0;
        end else if (rv) begin
            m_pc = t - (t % 4);
            if (t % 4 != 0) e_fault = 1;
            e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 0;
        end else if (s) begin
            // nothing moves
        end else if (m_pc > 65536 - 4) begin
            e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 0;
            e_fault = 1; m_halted = 1;
        end else begin
            e_instr = mem[m_pc / 4];
            e_pc4   = m_pc + 4;
            e_valid = 1;
            e_count = e_count + 1;
            m_pc    = m_pc + 4;
            if (h) m_halted = 1;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rv,
                        input logic [31:0] t, input logic h, input string tag);
        rst_n = r; stall = s; redirect_valid = rv; redirect_target = t; halt_req = h;
        model_edge(r, s, rv, t, h);
        @(posedge clk);
        #1;
        chk({tag, ".imem_addr"},  imem_addr,            m_pc);
        chk({tag, ".instr"},      ifid_instr,           e_instr);
        chk({tag, ".pc_plus4"},   ifid_pc_plus4,        e_pc4);
        chk({tag, ".valid"},      {31'h0, ifid_valid},  {31'h0, e_valid});
        chk({tag, ".fault"},      {31'h0, fetch_fault}, {31'h0, e_fault});
        chk({tag, ".count"},      fetch_count,          e_count);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1, 0, 0, 32'h0, 0, tag);
    endtask

    initial begin
        logic [31:0] cnt_before;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;

        // reset values
        step(0, 0, 0, 32'h0, 0, "reset");
        step(0, 1, 1, 32'h44, 1, "reset2");

        // boot then first two fetches
        step(1, 0, 0, 32'h0, 0, "boot");
        step(1, 0, 0, 32'h0, 0, "first");
        chk("first_instr_const", ifid_instr, 32'h2008_0005);
        chk("first_pc4_const", ifid_pc_plus4, 32'h4);
        step(1, 0, 0, 32'h0, 0, "second");
        chk("second_instr_const", ifid_instr, 32'h2009_0003);
        chk("second_pc4_const", ifid_pc_plus4, 32'h8);

        // stall three cycles at pc=0x8
        cnt_before = fetch_count;
        for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0, 0, "stall");
        chk("stall_addr_const", imem_addr, 32'h8);
        chk("stall_count_held", fetch_count, cnt_before);
        step(1, 0, 0, 32'h0, 0, "resume");
        chk("resume_addr_const", imem_addr, 32'hC);

        // redirect beats stall
        step(1, 1, 1, 32'h40, 0, "redir_stall");
        step(1, 0, 0, 32'h0, 0, "redir_target");
        chk("redir_pc4_const", ifid_pc_plus4, 32'h44);

        // misaligned redirect sets sticky fault
        step(1, 0, 1, 32'h42, 0, "misalign");
        chk("misalign_addr_const", imem_addr, 32'h40);
        run(3, "fault_sticky");

        // randomized traffic, no halt
        for (int i = 0; i < 200; i++) begin
            logic        s;
            logic        rv;
            logic [31:0] t;
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 9) == 0);
            t  = 32'($urandom_range(0, 32'h3FF));
            step(1, s, rv, t, 0, "random");
        end

        // end of memory: fetch 0xFFFC then fault and halt
        step(0, 0, 0, 32'h0, 0, "reset_range");
        step(1, 0, 0, 32'h0, 0, "boot_range");
        step(1, 0, 1, 32'hFFF0, 0, "jump_top");
        run(4, "top_fetch");
        chk("top_last_pc4_const", ifid_pc_plus4, 32'h0001_0000);
        step(1, 0, 0, 32'h0, 0, "over_end");
        chk("over_end_addr_const", imem_addr, 32'h0001_0000);
        step(1, 1, 1, 32'h80, 1, "halted_ignore");
        step(1, 0, 0, 32'h0, 0, "halted_frozen");

        // halt after ten fetches
        step(0, 0, 0, 32'h0, 0, "reset_halt");
        step(1, 0, 0, 32'h0, 0, "boot_halt");
        run(10, "ten");
        step(1, 0, 0, 32'h0, 1, "halt_pulse");
        chk("halt_count_const", fetch_count, 32'd11);
        for (int i = 0; i < 4; i++)
            step(1, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), "post_halt");

        // reset mid-operation overrides other inputs
        step(1, 0, 0, 32'h0, 0, "pre_reset");
        step(0, 1, 1, 32'h100, 1, "mid_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
